sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Parametrised arbiter that lets N_CH CPU-side SRAM-like request channels (instruction fetch, data load/store, future debug/DMA) share a single synchronous SRAM port with fixed read latency RD_LAT. It replaces the direct always-enabled SRAM wiring in the CPU top level with request/accept/response handshakes, which lets the mips core stall on contention or slow memory. The block sits between the core's fetch/memory stages and the inst/data SRAM port.

## Interface
- N_CH, 2, number of requesting channels (1..8); channel 0 is highest fixed priority
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8
- RD_LAT, 1, cycles from an SRAM access to a valid sram_rdata (1..4)

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- ch_req  in  N_CH  per-channel request; held until accepted
- ch_wen  in  N_CH*BE_W  per-channel byte write enables; 0 = read
- ch_addr  in  N_CH*ADDR_W  per-channel address
- ch_wdata  in  N_CH*DATA_W  per-channel write data
- ch_addr_ok  out  N_CH  one-hot; request accepted this cycle
- ch_data_ok  out  N_CH  one-hot; response for that channel this cycle
- ch_rdata  out  DATA_W  response data, shared, valid with any ch_data_ok
- sram_en  out  1  SRAM access this cycle
- sram_wen  out  BE_W  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after access
- busy  out  1  at least one access in flight

## Operation
- Grant: each cycle at most one channel with ch_req=1 is granted (combinational). Granted channel gets ch_addr_ok=1; its wen/addr/wdata drive the SRAM port with sram_en=1.
- No grant: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, ch_addr_ok=0.
- Handshake: a transfer occurs on a cycle with ch_req[i] & ch_addr_ok[i]. The requester must hold req/wen/addr/wdata stable until then. Dropping req before accept is legal; it withdraws the request.
- Tracking: a RD_LAT-deep shift pipeline of {valid, ch_id} entries. An accept enters stage 1; each entry advances one stage per cycle.
- Response: when the entry leaves stage RD_LAT, ch_data_ok[ch_id]=1 and ch_rdata=sram_rdata. Reads and writes both return data_ok. For writes, ch_rdata is don't-care.
- Ordering: responses come back in accept order, one per cycle at most. Throughput is one access per cycle with no bubbles.
- busy = OR of all pipeline valid bits.
- Reset (async assert): pipeline valids cleared, RR pointer = 0. All outputs go to 0 immediately. In-flight accesses are dropped and never produce data_ok. Writes already issued to the SRAM are not rolled back.

## Timing
- Accept at cycle t gives data_ok at cycle t+RD_LAT.
- ch_addr_ok and the sram_* outputs are combinational from ch_req and the arbiter state. ch_data_ok and ch_rdata-select are driven from registers; the ch_rdata value passes through combinationally from sram_rdata.
- Simultaneous requests: exactly one grant. Losers see addr_ok=0 and keep requesting.
- Accept and response in the same cycle for the same channel is legal and independent.
- Reset values: ch_addr_ok=0, ch_data_ok=0, ch_rdata=0, sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, busy=0.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at pointer p and proceeds upward with wrap mod N_CH. On a grant to channel g, p <= (g+1) mod N_CH. p is unchanged when there is no grant.
- Not defined: fixed priority, lowest index wins. No pointer register; a continuously requesting channel 0 starves all others.

## Test plan
- Single read, RD_LAT=1: ch0 req addr 0x100 at t. Required: ch_addr_ok=01 and sram_addr=0x100, sram_en=1, sram_wen=0 at t. With sram_rdata=0xDEADBEEF at t+1, ch_data_ok=01 and ch_rdata=0xDEADBEEF at t+1.
- Write, RD_LAT=2: ch1 wen=0011, addr 0x200, wdata 0x00001234. Required: sram_wen=0011, sram_wdata=0x00001234 same cycle; ch_data_ok=10 two cycles later; busy=1 for those two cycles.
- Contention, fixed priority (macro off): ch0 and ch1 both request for 3 cycles, then ch0 drops. Required: grants 0,0,0, then ch1 on cycle 4.
- Contention, round-robin (macro on): ch0 and ch1 request continuously for 4 cycles from reset. Required: grants 0,1,0,1 and data_ok in the same order.
- Pipelining, RD_LAT=3: ch0 back-to-back reads A, B, C at t..t+2. Required: data_ok at t+3, t+4, t+5, each carrying the sram_rdata of its own cycle.
- Reset mid-flight, RD_LAT=3: resetn low with 2 accesses in flight, then released. Required: all outputs 0 asynchronously; busy=0; no ch_data_ok in the following 5 cycles; round-robin pointer restarts at 0.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between CPU-side request channels and the shared synchronous SRAM port.
// master: requesters plus SRAM model side; slave: the arbiter.
interface sram_port_arbiter_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [N_CH-1:0]        ch_req;
    logic [N_CH*BE_W-1:0]   ch_wen;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH-1:0]        ch_addr_ok;
    logic [N_CH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]      ch_rdata;
    logic                   sram_en;
    logic [BE_W-1:0]        sram_wen;
    logic [ADDR_W-1:0]      sram_addr;
    logic [DATA_W-1:0]      sram_wdata;
    logic [DATA_W-1:0]      sram_rdata;
    logic                   busy;

    modport master (
        output ch_req, ch_wen, ch_addr, ch_wdata, sram_rdata,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata, busy
    );

    modport slave (
        input  ch_req, ch_wen, ch_addr, ch_wdata, sram_rdata,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata, busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency SRAM port among N_CH request channels; responses return in accept order.
// SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration, otherwise fixed priority (channel 0 highest).
module sram_port_arbiter #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                resetn,
    sram_port_arbiter_if.slave  bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              grant_vld;
    logic [CH_W-1:0]   grant_id;
    logic [N_CH-1:0]   addr_ok;
    logic [N_CH-1:0]   data_ok;
    logic [BE_W-1:0]   port_wen;
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_wdata;
    logic [RD_LAT-1:0] pipe_vld;
    logic [CH_W-1:0]   pipe_id [RD_LAT];

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cand;

    // Search upward from the pointer with wrap; first requester found wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cand = CH_W'((32'(rr_ptr) + k) % N_CH);
            if (!grant_vld && resetn && bus.ch_req[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (32'(grant_id) == N_CH - 1) ? '0 : grant_id + CH_W'(1);
        end
    end
`else
    // Lowest requesting index wins; descending scan leaves the lowest one last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            if (resetn && bus.ch_req[k]) begin
                grant_vld = 1'b1;
                grant_id  = CH_W'(k);
            end
        end
    end
`endif

    // Steer the granted channel onto the SRAM port; idle port drives all zeros.
    always_comb begin
        addr_ok    = '0;
        port_wen   = '0;
        port_addr  = '0;
        port_wdata = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (grant_vld && (grant_id == CH_W'(k))) begin
                addr_ok[k] = 1'b1;
                port_wen   = bus.ch_wen[k*BE_W +: BE_W];
                port_addr  = bus.ch_addr[k*ADDR_W +: ADDR_W];
                port_wdata = bus.ch_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // In-flight tracker: one {valid, channel} entry per outstanding SRAM cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_id[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= grant_vld;
            pipe_id[0]  <= grant_id;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        data_ok = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (pipe_vld[RD_LAT-1] && (pipe_id[RD_LAT-1] == CH_W'(k))) begin
                data_ok[k] = 1'b1;
            end
        end
    end

    assign bus.ch_addr_ok = addr_ok;
    assign bus.sram_en    = grant_vld;
    assign bus.sram_wen   = port_wen;
    assign bus.sram_addr  = port_addr;
    assign bus.sram_wdata = port_wdata;
    assign bus.ch_data_ok = data_ok;
    // Read data is a pass-through, zeroed when no response is due so reset leaves it at 0.
    assign bus.ch_rdata   = pipe_vld[RD_LAT-1] ? bus.sram_rdata : '0;
    assign bus.busy       = |pipe_vld;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are checked
// every cycle against a queue-based model, plus literal pins on selected cycles.
module tb_sram_port_arbiter;
    localparam int unsigned N_CH   = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N_CH-1:0]        req   = '0;
    logic [N_CH*BE_W-1:0]   wen   = '0;
    logic [N_CH*ADDR_W-1:0] addr  = '0;
    logic [N_CH*DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0]      rdata = '0;

    sram_port_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1 ();
    sram_port_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) b3 ();

    assign b1.ch_req = req;  assign b1.ch_wen = wen;  assign b1.ch_addr = addr;
    assign b1.ch_wdata = wdata;  assign b1.sram_rdata = rdata;
    assign b3.ch_req = req;  assign b3.ch_wen = wen;  assign b3.ch_addr = addr;
    assign b3.ch_wdata = wdata;  assign b3.sram_rdata = rdata;

    sram_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(b1));
    sram_port_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .bus(b3));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual 0x%0h required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: outstanding accesses per instance, each due exactly lat cycles after accept.
    typedef struct { int lat; int ch; int due; bit rd; } ent_t;
    ent_t mq[$];
    int   m_ptr = 0;

    typedef struct { int at; int sel; logic [63:0] val; } pin_t;
    pin_t pins[$];
    int   pins_hit = 0;
    logic fin_req  = 1'b0;
    logic fin_done = 1'b0;

    task automatic pin(input int dc, input int sel, input logic [63:0] v);
        pin_t p;
        p.at = cyc + dc; p.sel = sel; p.val = v;
        pins.push_back(p);
    endtask

    function automatic logic [63:0] sig(input int s);
        case (s)
            0:  return 64'(b1.ch_addr_ok);
            1:  return 64'(b1.sram_addr);
            2:  return 64'(b1.sram_en);
            3:  return 64'(b1.ch_data_ok);
            4:  return 64'(b1.ch_rdata);
            5:  return 64'(b3.sram_wen);
            6:  return 64'(b3.sram_wdata);
            7:  return 64'(b3.ch_data_ok);
            8:  return 64'(b3.busy);
            9:  return 64'(b3.ch_rdata);
            10: return 64'(b1.busy);
            default: return 64'(b3.ch_addr_ok);
        endcase
    endfunction

    always @(negedge clk) begin
        int g, idx, lat;
        logic inflight, rdchk, due_now;
        logic [N_CH-1:0]   e_ok, e_dok, a_dok;
        logic [BE_W-1:0]   e_wen;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd, a_rd;
        logic              a_busy;
        if (!resetn) begin
            chk("rst L1 ctl", 64'({b1.ch_addr_ok, b1.ch_data_ok, b1.sram_en, b1.busy, b1.sram_wen}), 64'h0);
            chk("rst L1 data", 64'({b1.ch_rdata, b1.sram_addr}), 64'h0);
            chk("rst L1 wdata", 64'(b1.sram_wdata), 64'h0);
            chk("rst L3 ctl", 64'({b3.ch_addr_ok, b3.ch_data_ok, b3.sram_en, b3.busy, b3.sram_wen}), 64'h0);
            chk("rst L3 data", 64'({b3.ch_rdata, b3.sram_addr}), 64'h0);
            chk("rst L3 wdata", 64'(b3.sram_wdata), 64'h0);
            mq.delete();
            m_ptr = 0;
        end else begin
            g = -1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < int'(N_CH); k++) begin
                idx = (m_ptr + k) % int'(N_CH);
                if (g < 0 && req[idx]) g = idx;
            end
`else
            for (int k = 0; k < int'(N_CH); k++) begin
                if (g < 0 && req[k]) g = k;
            end
`endif
            e_ok = '0; e_wen = '0; e_addr = '0; e_wd = '0;
            if (g >= 0) begin
                e_ok[g] = 1'b1;
                e_wen   = wen[g*BE_W +: BE_W];
                e_addr  = addr[g*ADDR_W +: ADDR_W];
                e_wd    = wdata[g*DATA_W +: DATA_W];
            end
            chk("L1 addr_ok", 64'(b1.ch_addr_ok), 64'(e_ok));
            chk("L1 sram_en", 64'(b1.sram_en), 64'(g >= 0));
            chk("L1 sram_wen", 64'(b1.sram_wen), 64'(e_wen));
            chk("L1 sram_addr", 64'(b1.sram_addr), 64'(e_addr));
            chk("L1 sram_wdata", 64'(b1.sram_wdata), 64'(e_wd));
            chk("L3 addr_ok", 64'(b3.ch_addr_ok), 64'(e_ok));
            chk("L3 sram_port", 64'({b3.sram_en, b3.sram_wen, b3.sram_addr}), 64'({g >= 0, e_wen, e_addr}));
            chk("L3 sram_wdata", 64'(b3.sram_wdata), 64'(e_wd));

            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 1 : 3;
                idx = -1; inflight = 1'b0;
                foreach (mq[j]) begin
                    if (mq[j].lat == lat) begin
                        inflight = 1'b1;
                        if (idx < 0) idx = j;
                    end
                end
                e_dok = '0; rdchk = 1'b0; due_now = 1'b0;
                if (idx >= 0 && mq[idx].due == cyc) begin
                    due_now = 1'b1;
                    e_dok[mq[idx].ch] = 1'b1;
                    rdchk = mq[idx].rd;
                end
                a_dok  = (d == 0) ? b1.ch_data_ok : b3.ch_data_ok;
                a_rd   = (d == 0) ? b1.ch_rdata   : b3.ch_rdata;
                a_busy = (d == 0) ? b1.busy       : b3.busy;
                chk($sformatf("L%0d data_ok", lat), 64'(a_dok), 64'(e_dok));
                if (rdchk) chk($sformatf("L%0d rdata", lat), 64'(a_rd), 64'(rdata));
                chk($sformatf("L%0d busy", lat), 64'(a_busy), 64'(inflight));
                if (due_now) mq.delete(idx);
            end

            foreach (pins[j]) begin
                if (pins[j].at == cyc) begin
                    pins_hit++;
                    chk($sformatf("pin sel%0d", pins[j].sel), sig(pins[j].sel), pins[j].val);
                end
            end

            if (g >= 0) begin
                ent_t e;
                e.ch = g;
                e.rd = (wen[g*BE_W +: BE_W] == '0);
                e.lat = 1; e.due = cyc + 1; mq.push_back(e);
                e.lat = 3; e.due = cyc + 3; mq.push_back(e);
                m_ptr = (g + 1) % int'(N_CH);
            end
        end
        if (fin_req && !fin_done) begin
            chk("all pins reached", 64'(pins_hit), 64'(pins.size()));
            fin_done = 1'b1;
        end
    end

    task automatic drive(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] w0, input logic [3:0] w1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] rd);
        req = r; addr = {a1, a0}; wen = {w1, w0}; wdata = {d1, d0}; rdata = rd;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 0, 0, 4'h0, 4'h0, 0, 0, 32'hC0DE_0000 + 32'(cyc));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        idle(2);

        // Single read on ch0
        pin(0, 0, 64'h1); pin(0, 1, 64'h100); pin(0, 2, 64'h1);
        pin(1, 3, 64'h1); pin(1, 4, 64'hDEAD_BEEF);
        pin(3, 7, 64'h1); pin(3, 9, 64'(32'hC0DE_0000 + 32'(cyc + 3)));
        drive(2'b01, 32'h100, 0, 4'h0, 4'h0, 0, 0, 32'h5555_5555);
        drive(2'b00, 0, 0, 4'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
        idle(4);

        // Partial write on ch1
        pin(0, 5, 64'h3); pin(0, 6, 64'h1234);
        pin(1, 8, 64'h1); pin(2, 8, 64'h1); pin(3, 8, 64'h1); pin(4, 8, 64'h0);
        pin(3, 7, 64'h2); pin(1, 3, 64'h2); pin(1, 10, 64'h1); pin(2, 10, 64'h0);
        drive(2'b10, 0, 32'h200, 4'h0, 4'h3, 0, 32'h0000_1234, 32'h0);
        idle(5);

        // Contention: both for 3 cycles, then ch1 alone
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        pin(0, 0, 64'h1); pin(1, 0, 64'h2); pin(2, 0, 64'h1); pin(3, 0, 64'h2);
        pin(2, 3, 64'h2);
`else
        pin(0, 0, 64'h1); pin(1, 0, 64'h1); pin(2, 0, 64'h1); pin(3, 0, 64'h2);
        pin(2, 3, 64'h1);
`endif
        pin(1, 3, 64'h1);
        repeat (3) drive(2'b11, 32'h300, 32'h400, 4'h0, 4'hF, 0, 32'hCAFE_0001, 32'h0);
        drive(2'b10, 32'h300, 32'h400, 4'h0, 4'hF, 0, 32'hCAFE_0001, 32'h0);
        idle(5);

        // Back-to-back reads, each response carries the SRAM data of its own cycle
        pin(3, 7, 64'h1); pin(4, 7, 64'h1); pin(5, 7, 64'h1); pin(6, 7, 64'h0);
        pin(3, 9, 64'hAAAA_0001); pin(4, 9, 64'hBBBB_0002); pin(5, 9, 64'hCCCC_0003);
        pin(2, 1, 64'hC00);
        drive(2'b01, 32'hA00, 0, 4'h0, 4'h0, 0, 0, 32'h0);
        drive(2'b01, 32'hB00, 0, 4'h0, 4'h0, 0, 0, 32'h0);
        drive(2'b01, 32'hC00, 0, 4'h0, 4'h0, 0, 0, 32'h0);
        drive(2'b00, 0, 0, 4'h0, 4'h0, 0, 0, 32'hAAAA_0001);
        drive(2'b00, 0, 0, 4'h0, 4'h0, 0, 0, 32'hBBBB_0002);
        drive(2'b00, 0, 0, 4'h0, 4'h0, 0, 0, 32'hCCCC_0003);
        idle(3);

        // Reset with two accesses in flight, requests still asserted
        drive(2'b10, 0, 32'hE00, 4'h0, 4'h0, 0, 0, 32'h0);
        drive(2'b01, 32'hD00, 0, 4'h0, 4'h0, 0, 0, 32'h0);
        req = 2'b11;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pin(k, 7, 64'h0); pin(k, 8, 64'h0); pin(k, 3, 64'h0);
        end
        idle(5);
        pin(0, 0, 64'h1); pin(0, 11, 64'h1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        pin(1, 0, 64'h2);
`else
        pin(1, 0, 64'h1);
`endif
        repeat (2) drive(2'b11, 32'hF00, 32'hF04, 4'h0, 4'h0, 0, 0, 32'h1234_5678);
        idle(5);

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 60; k++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom,
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  $urandom, $urandom, $urandom);
        end
        idle(6);

        fin_req = 1'b1;
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
